// File: rtl/arb_rand_rr_lock.sv
`default_nettype none
// ============================================================================
// Module : arb_rand_rr_lock
// Brief  : N-input arbiter with fixed, round-robin or LFSR-random start index;
//          registered grant held until ack or requester withdrawal.
// Rev    : 1.0
// ============================================================================
module arb_rand_rr_lock #(
  parameter int                 N         = 4,
  parameter int                 PTR_W     = $clog2(N),
  parameter int                 LFSR_W    = 16,
  parameter logic [LFSR_W-1:0]  LFSR_SEED = 16'hACE1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N-1:0]      i_req,
  input  logic [1:0]        i_mode,
  input  logic              i_ack,
  input  logic              i_lfsr_load,
  input  logic [LFSR_W-1:0] i_lfsr_seed_in,
  output logic [N-1:0]      o_gnt,
  output logic              o_gnt_valid,
  output logic [PTR_W-1:0]  o_gnt_idx,
  output logic              o_drop
);

  localparam logic [0:0]       c_ST_IDLE    = 1'b0;
  localparam logic [0:0]       c_ST_GRANT   = 1'b1;
  localparam logic [1:0]       c_MODE_FIXED = 2'b00;
  localparam logic [1:0]       c_MODE_RR    = 2'b01;
  localparam logic [PTR_W:0]   c_N          = (PTR_W+1)'(N);
  localparam logic [PTR_W-1:0] c_LAST       = PTR_W'(N-1);
  localparam logic [N-1:0]     c_ONE        = N'(1);

  logic [0:0]        r_state;
  logic [N-1:0]      r_gnt;
  logic [PTR_W-1:0]  r_gnt_idx;
  logic              r_drop;
  logic [PTR_W-1:0]  r_ptr;
  logic [LFSR_W-1:0] r_lfsr;

  logic [PTR_W-1:0]  w_rnd_raw;
  logic [PTR_W-1:0]  w_rnd;
  logic [PTR_W-1:0]  w_rr_next;
  logic [PTR_W-1:0]  w_start;
  logic [PTR_W:0]    w_cand;
  logic [PTR_W-1:0]  w_win;
  logic              w_found;
  logic              w_fb;
  logic              w_ack_now;

  // Low LFSR bits can exceed N-1 when N is not a power of two; one fold suffices.
  assign w_rnd_raw = r_lfsr[PTR_W-1:0];
  assign w_rnd     = ({1'b0, w_rnd_raw} >= c_N) ? (w_rnd_raw - c_N[PTR_W-1:0]) : w_rnd_raw;
  assign w_rr_next = (r_gnt_idx == c_LAST) ? '0 : (r_gnt_idx + PTR_W'(1));
  assign w_ack_now = (r_state == c_ST_GRANT) && i_ack;
  assign w_fb      = r_lfsr[LFSR_W-1] ^ r_lfsr[LFSR_W-3] ^ r_lfsr[LFSR_W-4] ^ r_lfsr[LFSR_W-6];

  always_comb begin
    w_start = '0;
    if (i_mode == c_MODE_FIXED) begin
      w_start = '0;
    end else if (i_mode == c_MODE_RR) begin
      w_start = w_ack_now ? w_rr_next : r_ptr;
    end else begin
      w_start = w_rnd;
    end
  end

  // Circular search starting at w_start; the first requester found wins.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_cand  = '0;
    for (int k = 0; k < N; k++) begin
      w_cand = {1'b0, w_start} + (PTR_W+1)'(k);
      if (w_cand >= c_N) begin
        w_cand = w_cand - c_N;
      end
      if (!w_found && i_req[w_cand[PTR_W-1:0]]) begin
        w_found = 1'b1;
        w_win   = w_cand[PTR_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_lfsr <= LFSR_SEED;
    end else if (i_lfsr_load) begin
      r_lfsr <= (i_lfsr_seed_in == '0) ? LFSR_SEED : i_lfsr_seed_in;
    end else begin
      r_lfsr <= {r_lfsr[LFSR_W-2:0], w_fb};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= c_ST_IDLE;
      r_gnt     <= '0;
      r_gnt_idx <= '0;
      r_drop    <= 1'b0;
      r_ptr     <= '0;
    end else begin
      r_drop <= 1'b0;
      case (r_state)
        c_ST_IDLE: begin
          if (w_found) begin
            r_gnt     <= c_ONE << w_win;
            r_gnt_idx <= w_win;
            r_state   <= c_ST_GRANT;
          end
        end
        c_ST_GRANT: begin
          if (i_ack) begin
            if (i_mode == c_MODE_RR) begin
              r_ptr <= w_rr_next;
            end
            if (w_found) begin
              r_gnt     <= c_ONE << w_win;
              r_gnt_idx <= w_win;
            end else begin
              r_gnt     <= '0;
              r_gnt_idx <= '0;
              r_state   <= c_ST_IDLE;
            end
          end else if (!i_req[r_gnt_idx]) begin
            // Holder withdrew before ack: release without re-arbitrating.
            r_gnt     <= '0;
            r_gnt_idx <= '0;
            r_drop    <= 1'b1;
            r_state   <= c_ST_IDLE;
          end
        end
        default: begin
          r_gnt     <= '0;
          r_gnt_idx <= '0;
          r_state   <= c_ST_IDLE;
        end
      endcase
    end
  end

  assign o_gnt       = r_gnt;
  assign o_gnt_valid = |r_gnt;
  assign o_gnt_idx   = r_gnt_idx;
  assign o_drop      = r_drop;

endmodule
`default_nettype wire

// File: doc/arb_rand_rr_lock.md
Name: arb_rand_rr_lock

Overview:
- Parametrised N-input arbiter; successor to the 4-input combinational random-start picker.
- Selects one requester per arbitration: fixed priority, round-robin, or random start point from an internal LFSR.
- Grant is registered and held until acknowledged, or until the requester withdraws.
- Sits in front of shared router resources (port allocation, side buffer, ejection).

Parameters:
- N, 4, number of requesters (>=2, need not be a power of 2)
- PTR_W, $clog2(N), width of index/pointer
- LFSR_W, 16, LFSR width (fixed polynomial x^16+x^14+x^13+x^11+1, Fibonacci, shift toward MSB)
- LFSR_SEED, 16'hACE1, reset/default seed (must be nonzero)

Ports:
- clk  input  1  clock, all state on rising edge
- reset  input  1  asynchronous, active-high
- req  input  N  request vector, bit i = requester i
- mode  input  2  00 fixed (start 0), 01 round-robin, 1x random start
- ack  input  1  consumer accepts current grant this cycle
- lfsr_load  input  1  load lfsr_seed_in into LFSR
- lfsr_seed_in  input  LFSR_W  seed value
- gnt  output  N  registered one-hot grant
- gnt_valid  output  1  gnt is nonzero
- gnt_idx  output  PTR_W  binary index of granted requester
- drop  output  1  one-cycle pulse: grant withdrawn without ack

Behaviour:
- Reset (async, immediate): state=IDLE, gnt=0, gnt_valid=0, gnt_idx=0, drop=0, ptr=0, lfsr=LFSR_SEED.
- Start index S, sampled with mode at arbitration time:
  - fixed: S=0
  - round-robin: S=ptr
  - random: S=lfsr[PTR_W-1:0]; if S>=N, S=S-N (a single subtraction suffices)
- Search: first req bit at index S, S+1, ... N-1, then wrapping to 0 ... S-1.
- IDLE:
  - |req=1: arbitrate; next cycle gnt=onehot(winner), gnt_idx=winner, state=GRANT.
  - |req=0: stay IDLE, outputs zero.
  - Latency req->gnt is 1 cycle.
- GRANT: gnt/gnt_idx held stable.
  - ack=1:
    - round-robin: ptr <= (gnt_idx+1) mod N.
    - Same cycle, arbitrate again over current req. Round-robin uses S=(gnt_idx+1) mod N combinationally; other modes use the normal S.
    - Any winner: load it next cycle, stay GRANT (zero-bubble back-to-back).
    - No winner: gnt=0 next cycle, go IDLE.
  - ack=0 and req[gnt_idx]=0: withdrawal.
    - Next cycle gnt=0, gnt_valid=0, drop=1 for one cycle, state=IDLE, ptr unchanged.
    - No re-arbitration in that cycle.
  - ack=1 together with req[gnt_idx]=0: treated as ack (no drop).
- ptr changes only on ack in round-robin mode; fixed/random modes never modify ptr.
- LFSR:
  - Advances every cycle after reset.
  - lfsr_load=1: loads lfsr_seed_in; a zero seed loads LFSR_SEED instead. Load takes priority over advance.
  - Never reaches zero.
- mode changes are legal any cycle; they affect only the next arbitration, never a held grant.
- gnt is always one-hot or zero. gnt_valid = |gnt; gnt_idx is 0 when gnt=0.
- No combinational path from req/ack to outputs.

Test Plan:
- Fixed, N=4: req=4'b1010 in IDLE -> next cycle gnt=4'b0010, gnt_idx=1, gnt_valid=1; gnt held with ack=0 for 5 cycles.
- Round-robin, N=4: req=4'b1111 held, ack=1 every cycle from first grant -> gnt_idx sequence 0,1,2,3,0,1 with gnt_valid continuously 1; ptr=2 after 6 acks.
- Random, N=4: lfsr_load with seed 16'h0002, req=4'b0011 applied so arbitration sees lfsr[1:0]=2 (per reference model) -> search wraps, gnt_idx=0. req=4'b0001 with any seed -> always gnt_idx=0.
- Withdrawal: granted idx 2, ack=0, drop req[2] -> next cycle gnt=0, drop=1 for exactly 1 cycle, ptr unchanged. Reassert -> regrant after 1 cycle.
- Reset mid-GRANT: assert reset between clock edges with gnt=4'b0100 -> gnt=0 immediately (asynchronously); after release ptr=0, lfsr=16'hACE1; zero seed load yields 16'hACE1.
- N=5 random: LFSR low 3 bits=6, req=5'b00010 -> S=1, gnt_idx=1. Low bits=7, req=5'b00100 -> S=2, gnt_idx=2.
